// File: rtl/issue_completion_unit_if.sv
// Scoreboard-facing bundle of the issue/completion unit: head-of-queue issue
// handshake, completion feedback, flush and status.
interface issue_completion_unit_if #(
  parameter int SLOTS = 4
);
  localparam int CW = $clog2(SLOTS + 1);

  logic [31:0]   head_instr;
  logic [31:0]   head_pc;
  logic          head_ready;
  logic          kill;
  logic          start_head;
  logic          committing_instr;
  logic [31:0]   instr_to_finish;
  logic [31:0]   pc_to_finish;
  logic [CW-1:0] in_flight;
  logic          div_busy;

  // Scoreboard side.
  modport master (
    output head_instr, head_pc, head_ready, kill,
    input  start_head, committing_instr, instr_to_finish, pc_to_finish,
           in_flight, div_busy
  );

  // Issue/completion unit side.
  modport slave (
    input  head_instr, head_pc, head_ready, kill,
    output start_head, committing_instr, instr_to_finish, pc_to_finish,
           in_flight, div_busy
  );
endinterface

// File: rtl/issue_completion_unit.sv
// Tracks in-flight ops issued from the scoreboard head, counts down a per-class
// latency and reports completions lowest slot first; one non-pipelined divider.
module issue_completion_unit #(
  parameter int SLOTS   = 4,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 8,
  parameter int ALU_LAT = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  issue_completion_unit_if.slave bus
);
  localparam int CW      = $clog2(SLOTS + 1);
  localparam int IDX_W   = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int MAX_LAT = (MUL_LAT > DIV_LAT)
                         ? ((MUL_LAT > ALU_LAT) ? MUL_LAT : ALU_LAT)
                         : ((DIV_LAT > ALU_LAT) ? DIV_LAT : ALU_LAT);
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);
  localparam logic [CNT_W-1:0] ALU_CNT = CNT_W'(ALU_LAT - 1);

  typedef enum logic [1:0] {CLS_ALU, CLS_MUL, CLS_DIV} op_class_t;

  typedef struct packed {
    logic             valid;
    logic [31:0]      instr;
    logic [31:0]      pc;
    logic [CNT_W-1:0] cnt;
    logic             is_div;
  } slot_t;

  slot_t slots [SLOTS];

  op_class_t        head_class;
  logic [CNT_W-1:0] head_cnt;
  logic             have_free;
  logic [IDX_W-1:0] free_idx;
  logic             any_done;
  logic [IDX_W-1:0] done_idx;
  logic             div_busy_int;
  logic [CW-1:0]    valid_count;
  logic             issue;
  logic             commit;

  always_comb begin
    head_class = CLS_ALU;
    if (bus.head_instr[6:0] == 7'b0110011 && bus.head_instr[31:25] == 7'b0000001)
      head_class = bus.head_instr[14] ? CLS_DIV : CLS_MUL;
    unique case (head_class)
      CLS_MUL: head_cnt = MUL_CNT;
      CLS_DIV: head_cnt = DIV_CNT;
      default: head_cnt = ALU_CNT;
    endcase
  end

  // NOTE: every variable gets a default before the loop so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    have_free    = 1'b0;
    free_idx     = '0;
    any_done     = 1'b0;
    done_idx     = '0;
    div_busy_int = 1'b0;
    valid_count  = '0;
    // Walk high to low so the last hit is the lowest index.
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (!slots[i].valid) begin
        have_free = 1'b1;
        free_idx  = IDX_W'(i);
      end
      if (slots[i].valid && slots[i].cnt == '0) begin
        any_done = 1'b1;
        done_idx = IDX_W'(i);
      end
      if (slots[i].valid && slots[i].is_div) div_busy_int = 1'b1;
      valid_count = valid_count + CW'(slots[i].valid);
    end
  end

  assign issue  = bus.head_ready && (bus.head_instr != '0) && have_free &&
                  !(head_class == CLS_DIV && div_busy_int) && !bus.kill && !reset;
  assign commit = any_done && !bus.kill && !reset;

  assign bus.start_head       = issue;
  assign bus.committing_instr = commit;
  assign bus.instr_to_finish  = commit ? slots[done_idx].instr : '0;
  assign bus.pc_to_finish     = commit ? slots[done_idx].pc    : '0;
  assign bus.in_flight        = reset ? '0 : valid_count;
  assign bus.div_busy         = div_busy_int && !reset;

  // NOTE: only the valid bits are reset; payload fields are don't-care while a
  // slot is invalid, so they carry no reset.
  always_ff @(posedge clock) begin
    if (reset || bus.kill) begin
      for (int i = 0; i < SLOTS; i++) slots[i].valid <= 1'b0;
    end else begin
      for (int i = 0; i < SLOTS; i++) begin
        if (slots[i].valid && slots[i].cnt != '0)
          slots[i].cnt <= slots[i].cnt - CNT_W'(1);
        if (commit && done_idx == IDX_W'(i))
          slots[i].valid <= 1'b0;
        // The issue target is always an invalid slot, never the committing one.
        if (issue && free_idx == IDX_W'(i)) begin
          slots[i].valid  <= 1'b1;
          slots[i].instr  <= bus.head_instr;
          slots[i].pc     <= bus.head_pc;
          slots[i].cnt    <= head_cnt;
          slots[i].is_div <= (head_class == CLS_DIV);
        end
      end
    end
  end
endmodule

// File: tb/tb_issue_completion_unit.sv
// Directed bench for issue_completion_unit: default-latency instance plus an
// ALU_LAT=MUL_LAT=4 instance used to fill every slot.
module tb_issue_completion_unit;
  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  issue_completion_unit_if #(.SLOTS(4)) b0 ();
  issue_completion_unit_if #(.SLOTS(4)) b4 ();

  issue_completion_unit #(.SLOTS(4), .MUL_LAT(3), .DIV_LAT(8), .ALU_LAT(1)) u0 (
    .clock(clock), .reset(reset), .bus(b0)
  );
  issue_completion_unit #(.SLOTS(4), .MUL_LAT(4), .DIV_LAT(8), .ALU_LAT(4)) u4 (
    .clock(clock), .reset(reset), .bus(b4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clock);
    #1;
  endtask

  task automatic head0(input logic [31:0] instr, input logic [31:0] pc, input logic rdy);
    b0.head_instr = instr;
    b0.head_pc    = pc;
    b0.head_ready = rdy;
  endtask

  task automatic head4(input logic [31:0] instr, input logic [31:0] pc, input logic rdy);
    b4.head_instr = instr;
    b4.head_pc    = pc;
    b4.head_ready = rdy;
  endtask

  // Kill/reset scenario prologue: DIV, MUL, MUL issued back to back, then idle.
  task automatic fill_three();
    head0(32'h0220C1B3, 32'h500, 1'b1); @(negedge clock); check("fill_div_issue", b0.start_head, 1); next();
    head0(32'h022081B3, 32'h504, 1'b1); @(negedge clock); check("fill_mul1_issue", b0.start_head, 1); next();
    head0(32'h022091B3, 32'h508, 1'b1); @(negedge clock); check("fill_mul2_issue", b0.start_head, 1); next();
    head0(32'h0, 32'h0, 1'b0);          @(negedge clock); check("fill_in_flight", b0.in_flight, 3);
    check("fill_no_commit", b0.committing_instr, 0); next();
  endtask

  initial begin
    reset = 1'b1;
    b0.kill = 1'b0;
    b4.kill = 1'b0;
    head0(32'h00208033, 32'h10, 1'b1);
    head4(32'h0, 32'h0, 1'b0);
    next();
    @(negedge clock);
    check("rst_start_head", b0.start_head, 0);
    check("rst_commit", b0.committing_instr, 0);
    check("rst_in_flight", b0.in_flight, 0);
    check("rst_div_busy", b0.div_busy, 0);
    next();
    reset = 1'b0;
    head0(32'h0, 32'h0, 1'b0);
    @(negedge clock);
    check("idle_commit", b0.committing_instr, 0);
    check("idle_instr", b0.instr_to_finish, 0);
    next();

    // ALU op commits the cycle after issue.
    head0(32'h00208033, 32'h100, 1'b1);
    @(negedge clock);
    check("alu_start", b0.start_head, 1);
    check("alu_no_commit", b0.committing_instr, 0);
    check("alu_in_flight0", b0.in_flight, 0);
    next();
    head0(32'h0, 32'h0, 1'b0);
    @(negedge clock);
    check("alu_commit", b0.committing_instr, 1);
    check("alu_instr", b0.instr_to_finish, 32'h00208033);
    check("alu_pc", b0.pc_to_finish, 32'h100);
    check("alu_in_flight1", b0.in_flight, 1);
    next();
    @(negedge clock);
    check("alu_done_commit", b0.committing_instr, 0);
    check("alu_done_instr", b0.instr_to_finish, 0);
    check("alu_in_flight2", b0.in_flight, 0);
    next();

    // MUL then ALU: ALU overtakes, each commits once.
    head0(32'h022081B3, 32'h200, 1'b1);
    @(negedge clock); check("mul_start", b0.start_head, 1); next();
    head0(32'h00308133, 32'h204, 1'b1);
    @(negedge clock); check("mul_alu_start", b0.start_head, 1); check("mul_c1_commit", b0.committing_instr, 0); next();
    head0(32'h0, 32'h0, 1'b0);
    @(negedge clock);
    check("mul_c2_commit", b0.committing_instr, 1);
    check("mul_c2_instr", b0.instr_to_finish, 32'h00308133);
    check("mul_c2_in_flight", b0.in_flight, 2);
    next();
    @(negedge clock);
    check("mul_c3_commit", b0.committing_instr, 1);
    check("mul_c3_instr", b0.instr_to_finish, 32'h022081B3);
    check("mul_c3_pc", b0.pc_to_finish, 32'h200);
    check("mul_c3_in_flight", b0.in_flight, 1);
    next();
    @(negedge clock);
    check("mul_c4_commit", b0.committing_instr, 0);
    check("mul_c4_in_flight", b0.in_flight, 0);
    next();

    // DIV blocks a second DIV until the first commits.
    head0(32'h0220C1B3, 32'h300, 1'b1);
    @(negedge clock); check("div_start", b0.start_head, 1); check("div_busy_c0", b0.div_busy, 0); next();
    head0(32'h0220D1B3, 32'h304, 1'b1);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clock);
      check($sformatf("div_block_c%0d", c), b0.start_head, 0);
      check($sformatf("div_busy_c%0d", c), b0.div_busy, 1);
      check($sformatf("div_commit_c%0d", c), b0.committing_instr, (c == 8) ? 1 : 0);
      if (c == 8) check("div_c8_instr", b0.instr_to_finish, 32'h0220C1B3);
      next();
    end
    @(negedge clock);
    check("div2_start_c9", b0.start_head, 1);
    check("div_busy_c9", b0.div_busy, 0);
    check("div_in_flight_c9", b0.in_flight, 0);
    next();
    head0(32'h0, 32'h0, 1'b0);
    for (int c = 10; c <= 17; c++) begin
      @(negedge clock);
      check($sformatf("div2_commit_c%0d", c), b0.committing_instr, (c == 17) ? 1 : 0);
      if (c == 17) check("div2_instr", b0.instr_to_finish, 32'h0220D1B3);
      next();
    end
    @(negedge clock); check("div2_in_flight", b0.in_flight, 0); next();

    // Slot0 and slot2 done together; slot2 waits one cycle.
    head0(32'h022081B3, 32'h400, 1'b1); @(negedge clock); check("dd_a_start", b0.start_head, 1); next();
    head0(32'h00208033, 32'h404, 1'b1); @(negedge clock); check("dd_b_start", b0.start_head, 1); next();
    head0(32'h00308133, 32'h408, 1'b1);
    @(negedge clock);
    check("dd_c_start", b0.start_head, 1);
    check("dd_c2_instr", b0.instr_to_finish, 32'h00208033);
    check("dd_c2_in_flight", b0.in_flight, 2);
    next();
    head0(32'h0, 32'h0, 1'b0);
    @(negedge clock);
    check("dd_c3_instr", b0.instr_to_finish, 32'h022081B3);
    check("dd_c3_in_flight", b0.in_flight, 2);
    next();
    @(negedge clock);
    check("dd_c4_commit", b0.committing_instr, 1);
    check("dd_c4_instr", b0.instr_to_finish, 32'h00308133);
    check("dd_c4_pc", b0.pc_to_finish, 32'h408);
    next();
    @(negedge clock);
    check("dd_c5_commit", b0.committing_instr, 0);
    check("dd_c5_in_flight", b0.in_flight, 0);
    next();

    // kill while one of three slots is done.
    fill_three();
    head0(32'h00208033, 32'h50C, 1'b1);
    b0.kill = 1'b1;
    @(negedge clock);
    check("kill_commit", b0.committing_instr, 0);
    check("kill_start", b0.start_head, 0);
    check("kill_instr", b0.instr_to_finish, 0);
    check("kill_in_flight", b0.in_flight, 3);
    next();
    b0.kill = 1'b0;
    head0(32'h0, 32'h0, 1'b0);
    @(negedge clock);
    check("kill_after_in_flight", b0.in_flight, 0);
    check("kill_after_div_busy", b0.div_busy, 0);
    check("kill_after_commit", b0.committing_instr, 0);
    next();
    @(negedge clock); check("kill_after2_commit", b0.committing_instr, 0); next();

    // Same scenario with reset.
    fill_three();
    head0(32'h00208033, 32'h50C, 1'b1);
    reset = 1'b1;
    @(negedge clock);
    check("reset_commit", b0.committing_instr, 0);
    check("reset_start", b0.start_head, 0);
    check("reset_instr", b0.instr_to_finish, 0);
    check("reset_pc", b0.pc_to_finish, 0);
    check("reset_in_flight", b0.in_flight, 0);
    check("reset_div_busy", b0.div_busy, 0);
    next();
    reset = 1'b0;
    head0(32'h0, 32'h0, 1'b0);
    @(negedge clock);
    check("reset_after_in_flight", b0.in_flight, 0);
    check("reset_after_div_busy", b0.div_busy, 0);
    check("reset_after_commit", b0.committing_instr, 0);
    next();
    @(negedge clock); check("reset_after2_commit", b0.committing_instr, 0); next();

    // Fill all four slots of the long-latency instance.
    head4(32'h00208033, 32'h600, 1'b1); @(negedge clock); check("full_i0", b4.start_head, 1); next();
    head4(32'h00308133, 32'h604, 1'b1); @(negedge clock); check("full_i1", b4.start_head, 1); next();
    head4(32'h00408233, 32'h608, 1'b1); @(negedge clock); check("full_i2", b4.start_head, 1); next();
    head4(32'h00508333, 32'h60C, 1'b1); @(negedge clock); check("full_i3", b4.start_head, 1); next();
    head4(32'h00608433, 32'h610, 1'b1);
    @(negedge clock);
    check("full_blocked", b4.start_head, 0);
    check("full_c4_instr", b4.instr_to_finish, 32'h00208033);
    check("full_c4_in_flight", b4.in_flight, 4);
    next();
    @(negedge clock);
    check("full_retry_issue", b4.start_head, 1);
    check("full_c5_instr", b4.instr_to_finish, 32'h00308133);
    check("full_c5_in_flight", b4.in_flight, 3);
    next();
    head4(32'h0, 32'h0, 1'b0);
    @(negedge clock); check("full_c6_instr", b4.instr_to_finish, 32'h00408233); next();
    @(negedge clock); check("full_c7_instr", b4.instr_to_finish, 32'h00508333); next();
    @(negedge clock); check("full_c8_commit", b4.committing_instr, 0); next();
    @(negedge clock);
    check("full_c9_instr", b4.instr_to_finish, 32'h00608433);
    check("full_c9_pc", b4.pc_to_finish, 32'h610);
    next();
    @(negedge clock); check("full_c10_in_flight", b4.in_flight, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/issue_completion_unit.md
Name: issue_completion_unit

Overview:
- Sits directly downstream of the scoreboard. Consumes its head_instr/head_pc/head_ready outputs and drives its start_head input. Feeds back committing_instr/instr_to_finish when an issued op completes.
- Tracks up to SLOTS in-flight ops, each with a latency countdown set by instruction class (ALU, MUL, DIV). Models a pipelined multiplier and a single non-pipelined divider.

Parameters:
SLOTS, 4, number of in-flight tracking slots
MUL_LAT, 3, cycles from issue to completion for MUL-class ops (>=1)
DIV_LAT, 8, cycles from issue to completion for DIV-class ops (>=1); divider is not pipelined
ALU_LAT, 1, cycles from issue to completion for all other ops (>=1)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high; clears all slots
head_instr  in  32  scoreboard head instruction word
head_pc  in  32  scoreboard head PC
head_ready  in  1  scoreboard head has operands ready
kill  in  1  synchronous clear of all in-flight slots (pipeline flush)
start_head  out  1  issue strobe to scoreboard (combinational)
committing_instr  out  1  completion strobe to scoreboard (combinational from state)
instr_to_finish  out  32  instruction word completing this cycle
pc_to_finish  out  32  PC of completing instruction
in_flight  out  $clog2(SLOTS+1)  number of valid slots
div_busy  out  1  divider occupied

Behaviour:
- Slot state: valid, instr[31:0], pc[31:0], cnt (wide enough for max latency), is_div.
- Class decode on head_instr:
  - MUL: opcode[6:0]=0110011, funct7=0000001, funct3[2]=0.
  - DIV: same opcode/funct7, funct3[2]=1 (DIV/DIVU/REM/REMU).
  - ALU: everything else.
- Issue condition (combinational): start_head = head_ready & (head_instr != 0) & free slot exists & !(DIV class & div_busy) & !kill & !reset.
- Free-slot test uses registered valid bits only. A slot committing this cycle is not reusable until the next cycle.
- On issue, load the lowest-index free slot at the clock edge: valid=1, instr, pc, cnt=LAT-1, is_div=(class==DIV).
- Countdown: each cycle, every valid slot with cnt>0 decrements by 1. cnt saturates at 0.
- Done: a slot is done when valid & cnt==0.
- Completion:
  - committing_instr=1 when any slot is done. instr_to_finish/pc_to_finish come from the lowest-index done slot.
  - That slot clears valid at the edge. Other done slots hold at cnt==0 and complete on later cycles, lowest index first.
  - When committing_instr=0, instr_to_finish=0 and pc_to_finish=0.
- Latency: an op issued in cycle T completes, if not blocked, in cycle T+LAT. ALU_LAT=1 gives commit the cycle after issue.
- div_busy = OR of (valid & is_div). It clears at the edge where the DIV slot commits. The next DIV may issue the following cycle.
- Simultaneous issue and commit in the same cycle: both occur, into and from different slots. in_flight is unchanged.
- Full (all SLOTS valid): start_head=0 even with head_ready=1. The head is retried each cycle.
- kill:
  - Clears all valid bits at the edge. committing_instr and start_head are forced 0 that cycle.
  - A done slot in the kill cycle is discarded, not reported.
- reset: same effect as kill, with priority over all. Every output is 0 during and after reset until new issue.
  - A mid-countdown reset drops all ops.
- in_flight = popcount(valid), registered state only.
- Instruction words are the scoreboard's match key. No identical instr words are in flight simultaneously; the scoreboard guarantees this.

Test Plan:
- ALU op 0x00208033 (add) with head_ready=1 at cycle 5 -> start_head=1 at 5; committing_instr=1, instr_to_finish=0x00208033 at cycle 6; in_flight 0->1->0.
- MUL 0x022081B3 issued at cycle 10, ALU op issued at 11 -> ALU commits at 12, MUL commits at 13, each for exactly one cycle.
- DIV 0x0220C1B3 issued at cycle 0, second DIV presented at 1 -> start_head=0 cycles 1-8; div_busy=1 cycles 1-8; first DIV commits at 8; second DIV issues at 9.
- Issue 4 ALU ops in consecutive cycles with MUL_LAT=ALU_LAT=4 (SLOTS=4), 5th head ready -> start_head=0 until the first commit frees a slot; the 5th issues the cycle after that commit.
- Two slots reach cnt==0 in the same cycle (slot0, slot2) -> slot0 reported that cycle, slot2 the next cycle; no op lost.
- kill asserted with 3 slots valid, one of them done -> no commit that cycle; in_flight=0 next cycle. Repeat with reset -> identical result, all outputs 0.
